shift_seq_unit: RTL

Parametrised multi-cycle shift unit for the datapath.
- Selects the shift amount from one of four sources: three data inputs plus a constant.
- Latches the operand and applies SLL/SRL/SRA/ROR over several cycles, at most STEP bits per cycle.
- Uses a start/busy/done handshake so the control FSM can sequence it.
- Replaces the combinational shift-amount mux plus fixed shift register pair.

---
 rtl/shift_seq_pkg.sv | 26 ++
 rtl/shift_amt_sel.sv | 37 +++
 rtl/shift_seq_unit.sv | 118 +++++++++++
 3 files changed

// File: rtl/shift_seq_pkg.sv
// Shared encodings for the multi-cycle shift unit.
// Holds the op encodings, the amount-source select encodings and the FSM
// state type used by shift_seq_unit and shift_amt_sel.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_ROR = 2'b11
  } sh_op_t;

  typedef enum logic [1:0] {
    AMT_SRC0  = 2'b00,
    AMT_CONST = 2'b01,
    AMT_SRC2  = 2'b10,
    AMT_SRC3  = 2'b11
  } amt_sel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shift_amt_sel.sv
// Combinational 4:1 shift-amount mux.
// Ports:
//   amt_sel   - 00 amt_src0, 01 CONST_AMT, 10 amt_src2, 11 amt_src3
//   amt_src0/2/3 - full-width amount sources
//   amt       - low SHAMT_W bits of the selected source
module shift_amt_sel
  import shift_seq_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int SHAMT_W   = $clog2(DATA_W),
  parameter int CONST_AMT = 16
) (
  input  logic [1:0]         amt_sel,
  input  logic [DATA_W-1:0]  amt_src0,
  input  logic [DATA_W-1:0]  amt_src2,
  input  logic [DATA_W-1:0]  amt_src3,
  output logic [SHAMT_W-1:0] amt
);

  logic [DATA_W-1:0] sel_word;
  logic              unused_hi;

  always_comb begin
    sel_word = '0;
    case (amt_sel_t'(amt_sel))
      AMT_SRC0:  sel_word = amt_src0;
      AMT_CONST: sel_word = DATA_W'(CONST_AMT);
      AMT_SRC2:  sel_word = amt_src2;
      default:   sel_word = amt_src3;
    endcase
  end

  // Bits above the amount width are deliberately discarded.
  assign amt       = sel_word[SHAMT_W-1:0];
  assign unused_hi = ^sel_word[DATA_W-1:SHAMT_W];

endmodule

// File: rtl/shift_seq_unit.sv
// Multi-cycle shift unit with start/busy/done handshake.
// Latches the operand, op and selected amount on an accepted start, then
// shifts by at most STEP bits per cycle until the amount is exhausted.
// Ports:
//   clk, reset (async, active-low)
//   start            - request, accepted only while idle
//   op               - 00 SLL, 01 SRL, 10 SRA, 11 ROR
//   amt_sel          - amount source select
//   data_in          - operand
//   amt_src0/2/3     - amount sources
//   busy             - high while shifting or completing
//   done             - one-cycle completion pulse
//   result           - shift result, held until the next accepted start
module shift_seq_unit
  import shift_seq_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int SHAMT_W   = $clog2(DATA_W),
  parameter int STEP      = 1,
  parameter int CONST_AMT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [1:0]        amt_sel,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] amt_src0,
  input  logic [DATA_W-1:0] amt_src2,
  input  logic [DATA_W-1:0] amt_src3,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam logic [SHAMT_W-1:0] STEP_AMT = SHAMT_W'(STEP);

  state_t             state_q, state_d;
  sh_op_t             op_q;
  logic [SHAMT_W-1:0] rem_q;
  logic [SHAMT_W-1:0] sel_amt;
  logic [SHAMT_W-1:0] step_amt;
  logic [DATA_W-1:0]  result_q;
  logic [DATA_W-1:0]  shifted;

  shift_amt_sel #(
    .DATA_W    (DATA_W),
    .SHAMT_W   (SHAMT_W),
    .CONST_AMT (CONST_AMT)
  ) u_amt_sel (
    .amt_sel  (amt_sel),
    .amt_src0 (amt_src0),
    .amt_src2 (amt_src2),
    .amt_src3 (amt_src3),
    .amt      (sel_amt)
  );

  // One pass applies step_amt single-bit shifts; unrolled STEP deep.
  always_comb begin
    step_amt = (rem_q < STEP_AMT) ? rem_q : STEP_AMT;
    shifted  = result_q;
    for (int unsigned i = 0; i < STEP; i++) begin
      if (i < 32'(step_amt)) begin
        case (op_q)
          SH_SLL:  shifted = {shifted[DATA_W-2:0], 1'b0};
          SH_SRL:  shifted = {1'b0, shifted[DATA_W-1:1]};
          SH_SRA:  shifted = {shifted[DATA_W-1], shifted[DATA_W-1:1]};
          default: shifted = {shifted[0], shifted[DATA_W-1:1]};
        endcase
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (sel_amt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (rem_q == step_amt) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_q <= '0;
      rem_q    <= '0;
      op_q     <= SH_SLL;
    end else if (state_q == IDLE && start) begin
      result_q <= data_in;
      op_q     <= sh_op_t'(op);
      rem_q    <= sel_amt;
    end else if (state_q == SHIFT) begin
      result_q <= shifted;
      rem_q    <= rem_q - step_amt;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule
